// File: rtl/cfg_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : cfg_stream_loader
// Description : Configuration producer for FUNC_CELL instances. Assembles a
//               framed, LSB-first configuration stream (valid/ready) into a
//               shadow register and commits a complete, well-formed frame
//               atomically to the flat config_sig bus. Malformed frames set a
//               sticky error and leave the active configuration untouched.
//               Cell k consumes config_sig[k*CELL_CFG_WIDTH +: CELL_CFG_WIDTH].
// Optional    : `define CFG_PARITY_EN adds cfg_in_parity (even parity of
//               cfg_in_data); a mismatching beat spoils the frame.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               cfg_in_valid/ready- stream handshake
//               cfg_in_data/last  - stream word, end-of-frame marker
//               cfg_in_parity     - (CFG_PARITY_EN only) even parity bit
//               config_sig        - active configuration bus
//               cfg_busy          - frame in progress
//               cfg_done          - one-cycle pulse on commit
//               cfg_error         - sticky frame error
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_stream_loader #(
  parameter int NUM_CELLS      = 4,
  parameter int CELL_CFG_WIDTH = 2,
  parameter int IN_WIDTH       = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cfg_in_valid,
  output logic                                cfg_in_ready,
  input  logic [IN_WIDTH-1:0]                 cfg_in_data,
  input  logic                                cfg_in_last,
`ifdef CFG_PARITY_EN
  input  logic                                cfg_in_parity,
`endif
  output logic [NUM_CELLS*CELL_CFG_WIDTH-1:0] config_sig,
  output logic                                cfg_busy,
  output logic                                cfg_done,
  output logic                                cfg_error
);

  localparam int TOTAL  = NUM_CELLS * CELL_CFG_WIDTH;
  localparam int NWORDS = (TOTAL + IN_WIDTH - 1) / IN_WIDTH;
  localparam int SHW    = NWORDS * IN_WIDTH;
  localparam int CNT_W  = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_DRAIN  = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic [TOTAL-1:0]   config_q, config_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic               w_beat;
  logic               w_par_ok;
  logic               w_final_word;
  logic               w_wr_en;
  logic [CNT_W-1:0]   w_wr_idx;
  logic [SHW-1:0]     w_pad;

`ifdef CFG_PARITY_EN
  assign w_par_ok = ~(^{cfg_in_data, cfg_in_parity});
`else
  assign w_par_ok = 1'b1;
`endif

  // Ready depends only on state (and reset) so the producer never sees a
  // combinational path from its own valid.
  assign cfg_in_ready = (state_q != S_COMMIT) && !reset;
  assign w_beat       = cfg_in_valid && cfg_in_ready;
  assign w_final_word = ((int'(word_cnt_q) + 1) == NWORDS);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    config_d   = config_q;
    error_d    = error_q;
    done_d     = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_idx   = word_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (w_beat) begin
          error_d    = 1'b0;
          w_wr_en    = 1'b1;
          w_wr_idx   = '0;
          word_cnt_d = CNT_W'(1);
          if (!w_par_ok) begin
            if (cfg_in_last) begin
              error_d    = 1'b1;
              word_cnt_d = '0;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (cfg_in_last && NWORDS == 1) begin
            state_d = S_COMMIT;
          end else if (cfg_in_last) begin
            // Short frame: ends before all words arrived.
            error_d    = 1'b1;
            word_cnt_d = '0;
          end else if (NWORDS == 1) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (w_beat) begin
          w_wr_en    = 1'b1;
          word_cnt_d = word_cnt_q + CNT_W'(1);
          if (!w_par_ok) begin
            if (cfg_in_last) begin
              error_d    = 1'b1;
              word_cnt_d = '0;
              state_d    = S_IDLE;
            end else begin
              state_d = S_DRAIN;
            end
          end else if (cfg_in_last && w_final_word) begin
            state_d = S_COMMIT;
          end else if (cfg_in_last) begin
            error_d    = 1'b1;
            word_cnt_d = '0;
            state_d    = S_IDLE;
          end else if (w_final_word) begin
            // All words present but no last marker: overlong frame.
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (w_beat && cfg_in_last) begin
          error_d    = 1'b1;
          word_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end

      S_COMMIT: begin
        config_d   = shadow_q;
        done_d     = 1'b1;
        word_cnt_d = '0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        word_cnt_d = '0;
      end
    endcase

    // Write into a word-aligned copy so the final word's excess bits fall
    // off when truncating back to TOTAL.
    w_pad              = '0;
    w_pad[TOTAL-1:0]   = shadow_q;
    if (w_wr_en) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (w == int'(w_wr_idx)) begin
          w_pad[w*IN_WIDTH +: IN_WIDTH] = cfg_in_data;
        end
      end
    end
    shadow_d = w_pad[TOTAL-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      shadow_q   <= '0;
      config_q   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      shadow_q   <= shadow_d;
      config_q   <= config_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign config_sig = config_q;
  assign cfg_busy   = (state_q != S_IDLE);
  assign cfg_done   = done_q;
  assign cfg_error  = error_q;

endmodule
`default_nettype wire

// File: tb/tb_cfg_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfg_stream_loader
// Description : Self-checking bench for cfg_stream_loader. Directed frames
//               followed by random frames, compared against a frame-level
//               reference model (words collected per frame, committed only
//               when the count and parity are right).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_stream_loader;

  localparam int NUM_CELLS      = 4;
  localparam int CELL_CFG_WIDTH = 2;
  localparam int IN_WIDTH       = 4;
  localparam int TOTAL          = NUM_CELLS * CELL_CFG_WIDTH;
  localparam int NWORDS         = (TOTAL + IN_WIDTH - 1) / IN_WIDTH;
`ifdef CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                cfg_in_valid;
  logic                cfg_in_ready;
  logic [IN_WIDTH-1:0] cfg_in_data;
  logic                cfg_in_last;
  logic                cfg_in_parity;
  logic [TOTAL-1:0]    config_sig;
  logic                cfg_busy;
  logic                cfg_done;
  logic                cfg_error;

  cfg_stream_loader #(
    .NUM_CELLS      (NUM_CELLS),
    .CELL_CFG_WIDTH (CELL_CFG_WIDTH),
    .IN_WIDTH       (IN_WIDTH)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_in_valid (cfg_in_valid),
    .cfg_in_ready (cfg_in_ready),
    .cfg_in_data  (cfg_in_data),
    .cfg_in_last  (cfg_in_last),
`ifdef CFG_PARITY_EN
    .cfg_in_parity(cfg_in_parity),
`endif
    .config_sig   (config_sig),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (frame level)
  int          m_n;        // words received in current frame
  logic [31:0] m_val;      // words assembled so far
  bit          m_bad;      // parity error seen in current frame
  logic [31:0] m_cfg;      // active configuration
  logic [31:0] m_pend_cfg; // configuration awaiting commit
  bit          m_pend;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_n = 0; m_val = 0; m_bad = 0; m_cfg = 0; m_pend_cfg = 0; m_pend = 0; m_err = 0;
  endfunction

  function automatic void model_beat(input logic [IN_WIDTH-1:0] d, input bit l, input bit p);
    if (PAR_EN && (p != ^d)) m_bad = 1;
    if (m_n < NWORDS) m_val = m_val | (32'(d) << (m_n * IN_WIDTH));
    m_n++;
    if (m_n == 1) m_err = 0;
    if (l) begin
      if (m_n == NWORDS && !m_bad) begin
        m_pend     = 1;
        m_pend_cfg = m_val & ((32'd1 << TOTAL) - 1);
      end else begin
        m_err = 1;
      end
      m_n = 0; m_val = 0; m_bad = 0;
    end
  endfunction

  task automatic drive_beat(input logic [IN_WIDTH-1:0] d, input bit l, input bit p);
    bit acc = 0;
    bit r;
    cfg_in_valid  = 1'b1;
    cfg_in_data   = d;
    cfg_in_last   = l;
    cfg_in_parity = p;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      r = cfg_in_ready;
      @(posedge clk);
      #1;
      if (r) acc = 1;
    end
    cfg_in_valid = 1'b0;
    cfg_in_last  = 1'b0;
    if (!acc) begin
      chk("beat_timeout", 32'd0, 32'd1);
    end else begin
      model_beat(d, l, p);
      chk("beat_error", 32'(cfg_error), 32'(m_err));
      chk("beat_busy", 32'(cfg_busy), 32'((m_n > 0) || m_pend));
      chk("beat_cfg", 32'(config_sig), m_cfg);
      chk("beat_done", 32'(cfg_done), 32'd0);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    chk("idle_done", 32'(cfg_done), 32'd0);
  endtask

  // Called right after a frame's last beat was accepted.
  task automatic finish_frame();
    if (m_pend) begin
      @(negedge clk);
      chk("commit_ready", 32'(cfg_in_ready), 32'd0);
      chk("commit_busy", 32'(cfg_busy), 32'd1);
      @(posedge clk);
      #1;
      m_cfg  = m_pend_cfg;
      m_pend = 0;
      chk("commit_done", 32'(cfg_done), 32'd1);
      chk("commit_cfg", 32'(config_sig), m_cfg);
      chk("commit_err", 32'(cfg_error), 32'd0);
      chk("commit_busy_after", 32'(cfg_busy), 32'd0);
      idle_cycle();
    end else begin
      idle_cycle();
      chk("err_cfg_kept", 32'(config_sig), m_cfg);
      chk("err_flag", 32'(cfg_error), 32'd1);
      chk("err_busy", 32'(cfg_busy), 32'd0);
    end
  endtask

  function automatic bit par(input logic [IN_WIDTH-1:0] d);
    return ^d;
  endfunction

  initial begin
    reset = 1'b1; cfg_in_valid = 1'b0; cfg_in_data = '0; cfg_in_last = 1'b0; cfg_in_parity = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(cfg_in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_cfg", 32'(config_sig), 32'd0);
    chk("reset_done", 32'(cfg_done), 32'd0);
    chk("reset_err", 32'(cfg_error), 32'd0);
    chk("reset_busy", 32'(cfg_busy), 32'd0);
    @(negedge clk);
    chk("idle_ready", 32'(cfg_in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: basic frame -> 0xE4, cells 0..3 get 0,1,2,3
    drive_beat(4'h4, 1'b0, par(4'h4));
    drive_beat(4'hE, 1'b1, par(4'hE));
    finish_frame();
    chk("t1_cfg", 32'(config_sig), 32'hE4);
    chk("t1_cell3", 32'(config_sig[7:6]), 32'd3);
    chk("t1_cell1", 32'(config_sig[3:2]), 32'd1);

    // 2: short frame
    drive_beat(4'h1, 1'b1, par(4'h1));
    finish_frame();
    chk("t2_cfg", 32'(config_sig), 32'hE4);

    // 3: overlong frame, then a valid all-zero frame
    drive_beat(4'h1, 1'b0, par(4'h1));
    drive_beat(4'h2, 1'b0, par(4'h2));
    drive_beat(4'h3, 1'b1, par(4'h3));
    finish_frame();
    drive_beat(4'h0, 1'b0, par(4'h0));
    chk("t3_err_clear", 32'(cfg_error), 32'd0);
    drive_beat(4'h0, 1'b1, par(4'h0));
    finish_frame();
    chk("t3_cfg", 32'(config_sig), 32'h00);

    // 4: gaps, then valid held across the COMMIT cycle
    drive_beat(4'h5, 1'b0, par(4'h5));
    repeat (3) idle_cycle();
    drive_beat(4'hA, 1'b1, par(4'hA));
    cfg_in_valid = 1'b1; cfg_in_data = 4'h1; cfg_in_last = 1'b0; cfg_in_parity = par(4'h1);
    @(negedge clk);
    chk("t4_commit_ready", 32'(cfg_in_ready), 32'd0);
    @(posedge clk);
    #1;
    m_cfg = m_pend_cfg; m_pend = 0;
    chk("t4_done", 32'(cfg_done), 32'd1);
    chk("t4_cfg", 32'(config_sig), 32'hA5);
    chk("t4_ready_back", 32'(cfg_in_ready), 32'd1);
    @(posedge clk);
    #1;
    cfg_in_valid = 1'b0;
    model_beat(4'h1, 1'b0, par(4'h1));
    chk("t4_held_busy", 32'(cfg_busy), 32'd1);
    chk("t4_done_pulse", 32'(cfg_done), 32'd0);
    drive_beat(4'h2, 1'b1, par(4'h2));
    finish_frame();
    chk("t4_cfg2", 32'(config_sig), 32'h21);

    // 5: reset mid-frame
    drive_beat(4'h4, 1'b0, par(4'h4));
    drive_beat(4'hE, 1'b1, par(4'hE));
    finish_frame();
    drive_beat(4'h7, 1'b0, par(4'h7));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("t5_cfg", 32'(config_sig), 32'd0);
    chk("t5_busy", 32'(cfg_busy), 32'd0);
    chk("t5_err", 32'(cfg_error), 32'd0);
    drive_beat(4'h1, 1'b0, par(4'h1));
    drive_beat(4'h0, 1'b1, par(4'h0));
    finish_frame();
    chk("t5_cfg2", 32'(config_sig), 32'h01);

    // 6: parity
    if (PAR_EN) begin
      drive_beat(4'h3, 1'b0, 1'b1);
      drive_beat(4'h0, 1'b1, par(4'h0));
      finish_frame();
      chk("t6_cfg_kept", 32'(config_sig), 32'h01);
      drive_beat(4'h3, 1'b0, par(4'h3));
      drive_beat(4'h0, 1'b1, par(4'h0));
      finish_frame();
      chk("t6_cfg", 32'(config_sig), 32'h03);
    end

    // Random frames
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, NWORDS + 1);
      for (int b = 0; b < len; b++) begin
        logic [IN_WIDTH-1:0] d;
        bit bad;
        repeat ($urandom_range(0, 2)) idle_cycle();
        d   = IN_WIDTH'($urandom_range(0, (1 << IN_WIDTH) - 1));
        bad = PAR_EN && ($urandom_range(0, 7) == 0);
        drive_beat(d, (b == len - 1), par(d) ^ bad);
      end
      finish_frame();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
